ppa_bk_pipe: RTL

- Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor.
- Built from the same ppa_pre / ppa_black / ppa_grey / ppa_post cell vocabulary, generalised to WIDTH bits.
- Adds three register stages, a subtract mode, signed overflow and a valid/ready handshake with full backpressure.
- Sits as the arithmetic engine behind any datapath that needs one add or subtract per cycle at a clock rate the combinational 4-bit adder cannot meet.

---
 rtl/ppa_bk_pipe.sv | 89 ++++++++
 1 files changed

// File: rtl/ppa_bk_pipe.sv
// ppa_bk_pipe: three-stage pipelined Brent-Kung adder/subtractor with valid/ready backpressure.
module ppa_bk_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int L = $clog2(WIDTH);
  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ppa_bk_pipe: WIDTH must be a power of two in 4..64");
  end
  logic             v1, v2, r1, r2, r3, cx, c1, c2;
  logic [WIDTH-1:0] bx, p0, g0, p1, g1, ug, up, p2, gg2, pp2, dg;
  logic [WIDTH:0]   c;
  assign r3       = !out_valid | out_ready;
  assign r2       = !v2 | r3;
  assign r1       = !v1 | r2;
  assign in_ready = r1;
  // Carry-in is folded into g[0] so the prefix tree yields carries directly.
  assign bx = b ^ {WIDTH{sub}};
  assign cx = cin ^ sub;
  assign p0 = a ^ bx;
  assign g0 = (a & bx) | {{(WIDTH-1){1'b0}}, p0[0] & cx};
  always_comb begin
    ug = g1;
    up = p1;
    for (int k = 0; k < L; k++)
      for (int i = (2 << k) - 1; i < WIDTH; i += 2 << k) begin
        ug[i] = ug[i] | (up[i] & ug[i - (1 << k)]);
        up[i] = up[i] & up[i - (1 << k)];
      end
  end
  // Grey cells fill the remaining prefixes from the up-sweep's power-of-two spans.
  always_comb begin
    dg = gg2;
    for (int k = L - 2; k >= 0; k--)
      for (int i = (3 << k) - 1; i < WIDTH; i += 2 << k)
        dg[i] = dg[i] | (pp2[i] & dg[i - (1 << k)]);
  end
  assign c = {dg, c2};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      p1        <= '0;
      g1        <= '0;
      c1        <= 1'b0;
      p2        <= '0;
      gg2       <= '0;
      pp2       <= '0;
      c2        <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (r1) v1 <= in_valid;
      if (r1 && in_valid) begin
        p1 <= p0;
        g1 <= g0;
        c1 <= cx;
      end
      if (r2) v2 <= v1;
      if (r2 && v1) begin
        p2  <= p1;
        gg2 <= ug;
        pp2 <= up;
        c2  <= c1;
      end
      if (r3) out_valid <= v2;
      if (r3 && v2) begin
        sum  <= p2 ^ c[WIDTH-1:0];
        cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule
